// File: rtl/multdiv_unit_if.sv
// multdiv_unit_if: operand, start and result signals of the multiply/divide unit
interface multdiv_unit_if #(parameter int WIDTH = 32);
  logic [WIDTH-1:0] data_operandA, data_operandB, data_result;
  logic ctrl_MULT, ctrl_DIV, data_exception, data_resultRDY, busy;
  modport master (
    output data_operandA, data_operandB, ctrl_MULT, ctrl_DIV,
    input  data_result, data_exception, data_resultRDY, busy
  );
  modport slave (
    input  data_operandA, data_operandB, ctrl_MULT, ctrl_DIV,
    output data_result, data_exception, data_resultRDY, busy
  );
endinterface

// File: rtl/multdiv_unit.sv
// multdiv_unit: iterative signed 32-bit shift-add multiply / restoring divide
module multdiv_unit #(
  parameter int WIDTH = 32,
  parameter int ITER  = WIDTH
) (
  input logic clk,
  input logic reset,
  multdiv_unit_if.slave md
);
  typedef enum logic [1:0] {IDLE, MULT, DIV, DONE} state_t;
  localparam int CW = $clog2(ITER);
  state_t state, state_nxt;
  logic [CW-1:0] cnt;
  logic [WIDTH-1:0] mc, abs_a, abs_b, q, res;
  logic [2*WIDTH-1:0] acc, acc_nxt, prod;
  logic [WIDTH:0] sum, rem_sh, diff;
  logic neg, start, last, exc;
  assign start = (state == IDLE || state == DONE) && (md.ctrl_MULT || md.ctrl_DIV);
  assign last  = cnt == CW'(ITER - 1);
  assign md.busy = state == MULT || state == DIV;
  assign md.data_resultRDY = state == DONE;
  always_comb begin
    state_nxt = start ? (md.ctrl_MULT ? MULT : DIV)
              : md.busy ? (last ? DONE : state) : IDLE;
  end
  // mc holds the multiplicand or divisor magnitude; acc is {hi, lo} for both ops
  always_comb begin
    abs_a   = md.data_operandA[WIDTH-1] ? -md.data_operandA : md.data_operandA;
    abs_b   = md.data_operandB[WIDTH-1] ? -md.data_operandB : md.data_operandB;
    sum     = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, mc} : '0);
    rem_sh  = acc[2*WIDTH-1:WIDTH-1];
    diff    = rem_sh - {1'b0, mc};
    acc_nxt = state == MULT ? {sum, acc[WIDTH-1:1]}
            : diff[WIDTH] ? {rem_sh[WIDTH-1:0], acc[WIDTH-2:0], 1'b0}
            : {diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
    prod    = neg ? -acc_nxt : acc_nxt;
    q       = acc_nxt[WIDTH-1:0];
    res     = state == MULT ? prod[WIDTH-1:0] : mc == '0 ? '0 : neg ? -q : q;
    // only |A|=2^31, |B|=1 yields a quotient magnitude with the top bit set
    exc     = state == MULT ? !(&prod[2*WIDTH-1:WIDTH-1] || !(|prod[2*WIDTH-1:WIDTH-1]))
            : (mc == '0 || (q[WIDTH-1] && !neg));
  end
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else state <= state_nxt;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt <= '0;
      acc <= '0;
      mc <= '0;
      neg <= 1'b0;
      md.data_result <= '0;
      md.data_exception <= 1'b0;
    end else if (start) begin
      cnt <= '0;
      neg <= md.data_operandA[WIDTH-1] ^ md.data_operandB[WIDTH-1];
      mc  <= md.ctrl_MULT ? abs_a : abs_b;
      acc <= {{WIDTH{1'b0}}, md.ctrl_MULT ? abs_b : abs_a};
    end else if (md.busy) begin
      cnt <= cnt + 1'b1;
      acc <= acc_nxt;
      if (last) begin
        md.data_result <= res;
        md.data_exception <= exc;
      end
    end
  end
endmodule

// File: tb/tb_multdiv_unit.sv
// tb_multdiv_unit: scoreboard bench for multdiv_unit covering results, exceptions, latency and busy
module tb_multdiv_unit;
  typedef struct {
    logic [31:0] res;
    logic exc;
    int cyc;
    string tag;
  } exp_t;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int cyc = 0;
  int n_chk = 0;
  int n_fail = 0;
  int busy_run = 0;
  exp_t sb[$];
  multdiv_unit_if #(32) md();
  multdiv_unit dut (.clk(clk), .reset(reset), .md(md));
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (md.data_resultRDY) begin
      if (sb.size() == 0) check("spurious_rdy", 64'(md.data_resultRDY), 64'd0);
      else begin
        exp_t e;
        e = sb.pop_front();
        check({e.tag, "_res"}, 64'(md.data_result), 64'(e.res));
        check({e.tag, "_exc"}, 64'(md.data_exception), 64'(e.exc));
        check({e.tag, "_lat"}, 64'(cyc), 64'(e.cyc));
        check({e.tag, "_busy"}, 64'(busy_run), 64'd32);
        check({e.tag, "_busy_done"}, 64'(md.busy), 64'd0);
      end
      busy_run = 0;
    end else busy_run = md.busy ? busy_run + 1 : 0;
  end

  task automatic op(input logic mul, input logic div, input logic [31:0] a, input logic [31:0] b,
                    input logic push, input logic [31:0] er, input logic ee, input string tag);
    @(negedge clk);
    md.ctrl_MULT = mul;
    md.ctrl_DIV = div;
    md.data_operandA = a;
    md.data_operandB = b;
    if (push) sb.push_back('{er, ee, cyc + 33, tag});
    @(negedge clk);
    md.ctrl_MULT = 1'b0;
    md.ctrl_DIV = 1'b0;
  endtask

  task automatic wait_done();
    for (int i = 0; i < 40 && sb.size() != 0; i++) @(negedge clk);
    check("timeout", 64'(sb.size()), 64'd0);
  endtask

  task automatic run(input logic mul, input logic div, input logic [31:0] a, input logic [31:0] b,
                     input logic [31:0] er, input logic ee, input string tag);
    op(mul, div, a, b, 1'b1, er, ee, tag);
    wait_done();
  endtask

  initial begin
    md.ctrl_MULT = 1'b0;
    md.ctrl_DIV = 1'b0;
    md.data_operandA = '0;
    md.data_operandB = '0;
    repeat (2) @(negedge clk);
    check("rst_res", 64'(md.data_result), 64'd0);
    check("rst_exc", 64'(md.data_exception), 64'd0);
    check("rst_rdy", 64'(md.data_resultRDY), 64'd0);
    check("rst_busy", 64'(md.busy), 64'd0);
    reset = 1'b0;
    run(1, 0, 32'd7, -32'sd3, 32'hFFFFFFEB, 0, "mul_7x-3");
    op(1, 0, 32'd7, -32'sd3, 1'b0, '0, 0, "");
    repeat (9) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("midrst_res", 64'(md.data_result), 64'd0);
    check("midrst_exc", 64'(md.data_exception), 64'd0);
    check("midrst_rdy", 64'(md.data_resultRDY), 64'd0);
    check("midrst_busy", 64'(md.busy), 64'd0);
    reset = 1'b0;
    repeat (40) @(negedge clk);
    run(1, 0, 32'h00010000, 32'h00010000, 32'h00000000, 1, "mul_ovf");
    run(1, 0, 32'h7FFFFFFF, 32'd1, 32'h7FFFFFFF, 0, "mul_max");
    run(1, 0, 32'h80000000, 32'd1, 32'h80000000, 0, "mul_min");
    run(1, 0, -32'sd4, -32'sd5, 32'd20, 0, "mul_negneg");
    run(0, 1, -32'sd7, 32'd2, 32'hFFFFFFFD, 0, "div_-7/2");
    run(0, 1, 32'd100, -32'sd7, 32'hFFFFFFF2, 0, "div_100/-7");
    run(0, 1, 32'd5, 32'd10, 32'd0, 0, "div_5/10");
    run(0, 1, 32'd123, 32'd0, 32'd0, 1, "div_by0");
    run(0, 1, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1, "div_ovf");
    run(0, 1, 32'h80000000, 32'd1, 32'h80000000, 0, "div_min/1");
    run(1, 1, 32'd6, 32'd3, 32'd18, 0, "both_start");
    op(0, 1, 32'd100, -32'sd7, 1'b1, 32'hFFFFFFF2, 0, "ignored");
    repeat (5) @(negedge clk);
    md.ctrl_MULT = 1'b1;
    md.ctrl_DIV = 1'b1;
    md.data_operandA = 32'd3;
    md.data_operandB = 32'd3;
    @(negedge clk);
    md.ctrl_MULT = 1'b0;
    md.ctrl_DIV = 1'b0;
    md.data_operandA = 32'd999;
    wait_done();
    op(1, 0, 32'd6, 32'd7, 1'b1, 32'd42, 0, "b2b_mul");
    for (int i = 0; i < 40 && !md.data_resultRDY; i++) @(negedge clk);
    md.ctrl_DIV = 1'b1;
    md.data_operandA = 32'd42;
    md.data_operandB = 32'd5;
    sb.push_back('{32'd8, 1'b0, cyc + 33, "b2b_div"});
    @(negedge clk);
    md.ctrl_DIV = 1'b0;
    repeat (10) @(negedge clk);
    check("hold_b2b", 64'(md.data_result), 64'd42);
    wait_done();
    repeat (3) @(negedge clk);
    check("hold_idle_res", 64'(md.data_result), 64'd8);
    check("hold_idle_rdy", 64'(md.data_resultRDY), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
